ram_arbiter: RTL and testbench

- Shares the single external 256KB 16-bit RAM between two masters.
- Master 1 is the CPU-side Wishbone path, the 16-bit output of the 64-to-16 bottleneck and bridge.
- Master 2 is the MGIA video fetch port.
- Video has priority, bounded by a burst limit so the CPU cannot starve. Sits between the address decoder's ram_en path and the Verilator-emulated RAM pins.

---
 rtl/ram_arbiter_pkg.sv | 29 ++
 rtl/ram_arbiter_mux.sv | 58 +++++
 rtl/ram_arbiter.sv | 119 +++++++++++
 tb/tb_ram_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the external RAM arbiter.
// Grant encodings double as the debug owner code on grant_o.
package ram_arbiter_pkg;

  localparam int unsigned RAM_AW  = 17;
  localparam int unsigned RAM_DW  = 16;
  localparam int unsigned BURST_W = 8;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'b00,
    GNT_CPU  = 2'b01,
    GNT_VID  = 2'b10
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_VID
  } arb_state_t;

  function automatic grant_t state_to_grant(input arb_state_t st);
    case (st)
      ST_CPU:  return GNT_CPU;
      ST_VID:  return GNT_VID;
      default: return GNT_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ram_arbiter_mux.sv
// Combinational RAM pin and acknowledge steering from the registered grant.
// Non-owners never see an ack; idle or strobe-low owners leave the pins inactive.
module ram_arbiter_mux
  import ram_arbiter_pkg::*;
(
  input  grant_t              grant_i,
  input  logic [RAM_AW-1:0]   cpu_adr_i,
  input  logic [RAM_DW-1:0]   cpu_dat_i,
  input  logic [1:0]          cpu_sel_i,
  input  logic                cpu_we_i,
  input  logic                cpu_stb_i,
  output logic                cpu_ack_o,
  output logic [RAM_DW-1:0]   cpu_dat_o,
  input  logic [RAM_AW-1:0]   vid_adr_i,
  input  logic                vid_stb_i,
  output logic                vid_ack_o,
  output logic [RAM_DW-1:0]   vid_dat_o,
  output logic [RAM_AW-1:0]   ram_adr_o,
  output logic [RAM_DW-1:0]   ram_dat_o,
  output logic [1:0]          ram_sel_o,
  output logic                ram_wen_o,
  output logic                ram_oen_o,
  input  logic                ram_ack_i,
  input  logic [RAM_DW-1:0]   ram_dat_i
);

  logic cpu_own;
  logic vid_own;

  assign cpu_own = (grant_i == GNT_CPU);
  assign vid_own = (grant_i == GNT_VID);

  always_comb begin
    ram_adr_o = '0;
    ram_dat_o = '0;
    ram_sel_o = 2'b00;
    ram_wen_o = 1'b1;
    ram_oen_o = 1'b1;
    if (cpu_own) begin
      ram_adr_o = cpu_adr_i;
      ram_dat_o = cpu_dat_i;
      ram_sel_o = cpu_sel_i;
      ram_wen_o = ~(cpu_stb_i & cpu_we_i);
      ram_oen_o = ~(cpu_stb_i & ~cpu_we_i);
    end else if (vid_own) begin
      // Video is a read-only, full-word master.
      ram_adr_o = vid_adr_i;
      ram_sel_o = 2'b11;
      ram_oen_o = ~vid_stb_i;
    end
  end

  assign cpu_ack_o = ram_ack_i & cpu_own & cpu_stb_i;
  assign vid_ack_o = ram_ack_i & vid_own & vid_stb_i;
  assign cpu_dat_o = ram_dat_i;
  assign vid_dat_o = ram_dat_i;

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter for the external 16-bit RAM: video has priority,
// bounded by a burst limit so a pending CPU cycle is served in bounded time.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | no owner, pins inactive, requests sampled for next cycle
//   ST_CPU  | CPU owns RAM for the whole cpu_cyc_i (multi-beat atomic)
//   ST_VID  | video owns RAM, counting acked words toward burst limit
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned VID_BURST_MAX = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [RAM_AW-1:0]   cpu_adr_i,
  input  logic [RAM_DW-1:0]   cpu_dat_i,
  input  logic [1:0]          cpu_sel_i,
  input  logic                cpu_we_i,
  input  logic                cpu_cyc_i,
  input  logic                cpu_stb_i,
  output logic                cpu_ack_o,
  output logic [RAM_DW-1:0]   cpu_dat_o,
  input  logic [RAM_AW-1:0]   vid_adr_i,
  input  logic                vid_stb_i,
  output logic                vid_ack_o,
  output logic [RAM_DW-1:0]   vid_dat_o,
  output logic [RAM_AW-1:0]   ram_adr_o,
  output logic [RAM_DW-1:0]   ram_dat_o,
  output logic [1:0]          ram_sel_o,
  output logic                ram_wen_o,
  output logic                ram_oen_o,
  input  logic                ram_ack_i,
  input  logic [RAM_DW-1:0]   ram_dat_i,
  output logic [1:0]          grant_o
);

  localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(VID_BURST_MAX);

  arb_state_t         state_q, state_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] burst_inc;
  logic               cpu_req;
  logic               vid_xfer_done;
  grant_t             grant;

  assign cpu_req       = cpu_cyc_i & cpu_stb_i;
  assign vid_xfer_done = ram_ack_i & vid_stb_i;
  assign burst_inc     = (burst_q == BURST_LIM) ? burst_q : burst_q + 1'b1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      ST_IDLE: begin
        burst_d = '0;
        if (vid_stb_i)    state_d = ST_VID;
        else if (cpu_req) state_d = ST_CPU;
      end
      ST_VID: begin
        // Hand over only on an ack boundary so no video transfer is cut short.
        if (vid_xfer_done) begin
          burst_d = burst_inc;
          if (cpu_req && burst_inc == BURST_LIM) begin
            state_d = ST_CPU;
            burst_d = '0;
          end
        end else if (!vid_stb_i) begin
          state_d = ST_IDLE;
          burst_d = '0;
        end
      end
      ST_CPU: begin
        burst_d = '0;
        if (!cpu_cyc_i) state_d = vid_stb_i ? ST_VID : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
    endcase
  end

  assign grant   = state_to_grant(state_q);
  assign grant_o = grant;

  ram_arbiter_mux u_mux (
    .grant_i   (grant),
    .cpu_adr_i (cpu_adr_i),
    .cpu_dat_i (cpu_dat_i),
    .cpu_sel_i (cpu_sel_i),
    .cpu_we_i  (cpu_we_i),
    .cpu_stb_i (cpu_stb_i),
    .cpu_ack_o (cpu_ack_o),
    .cpu_dat_o (cpu_dat_o),
    .vid_adr_i (vid_adr_i),
    .vid_stb_i (vid_stb_i),
    .vid_ack_o (vid_ack_o),
    .vid_dat_o (vid_dat_o),
    .ram_adr_o (ram_adr_o),
    .ram_dat_o (ram_dat_o),
    .ram_sel_o (ram_sel_o),
    .ram_wen_o (ram_wen_o),
    .ram_oen_o (ram_oen_o),
    .ram_ack_i (ram_ack_i),
    .ram_dat_i (ram_dat_i)
  );

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: reset, CPU read/write, priority, burst limit,
// release on video drop, spurious ack and asynchronous reset mid-write.
module tb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [16:0] cpu_adr_i;
  logic [15:0] cpu_dat_i;
  logic [1:0]  cpu_sel_i;
  logic        cpu_we_i, cpu_cyc_i, cpu_stb_i;
  logic        cpu_ack_o;
  logic [15:0] cpu_dat_o;
  logic [16:0] vid_adr_i;
  logic        vid_stb_i;
  logic        vid_ack_o;
  logic [15:0] vid_dat_o;
  logic [16:0] ram_adr_o;
  logic [15:0] ram_dat_o;
  logic [1:0]  ram_sel_o;
  logic        ram_wen_o, ram_oen_o;
  logic        ram_ack_i;
  logic [15:0] ram_dat_i;
  logic [1:0]  grant_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ram_arbiter #(.VID_BURST_MAX(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_sel_i(cpu_sel_i),
    .cpu_we_i(cpu_we_i), .cpu_cyc_i(cpu_cyc_i), .cpu_stb_i(cpu_stb_i),
    .cpu_ack_o(cpu_ack_o), .cpu_dat_o(cpu_dat_o),
    .vid_adr_i(vid_adr_i), .vid_stb_i(vid_stb_i),
    .vid_ack_o(vid_ack_o), .vid_dat_o(vid_dat_o),
    .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o), .ram_sel_o(ram_sel_o),
    .ram_wen_o(ram_wen_o), .ram_oen_o(ram_oen_o),
    .ram_ack_i(ram_ack_i), .ram_dat_i(ram_dat_i), .grant_o(grant_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_adr_i = '0; cpu_dat_i = '0; cpu_sel_i = 2'b00; cpu_we_i = 1'b0;
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    vid_adr_i = '0; vid_stb_i = 1'b0;
    ram_ack_i = 1'b0; ram_dat_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_i = 1'b1;
    #12;
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
    total++; if ({ram_wen_o, ram_oen_o} !== 2'b11) begin bad++; $display("FAIL reset_wen_oen got=%b exp=11", {ram_wen_o, ram_oen_o}); end
    total++; if ({ram_adr_o, ram_dat_o, ram_sel_o} !== 35'd0) begin bad++; $display("FAIL reset_pins got=%h exp=0", {ram_adr_o, ram_dat_o, ram_sel_o}); end
    total++; if ({cpu_ack_o, vid_ack_o} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b exp=00", {cpu_ack_o, vid_ack_o}); end
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_adr_i = 17'h00010; cpu_we_i = 1'b0; cpu_sel_i = 2'b11;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    #1;
    total++; if (ram_oen_o !== 1'b1 || grant_o !== 2'b00) begin bad++; $display("FAIL rd_latency oen=%b grant=%b exp oen=1 grant=00", ram_oen_o, grant_o); end
    tick();
    total++; if (grant_o !== 2'b01 || ram_oen_o !== 1'b0 || ram_wen_o !== 1'b1) begin bad++; $display("FAIL rd_grant grant=%b oen=%b wen=%b exp 01/0/1", grant_o, ram_oen_o, ram_wen_o); end
    total++; if (ram_adr_o !== 17'h00010) begin bad++; $display("FAIL rd_adr got=%h exp=00010", ram_adr_o); end
    ram_ack_i = 1'b1; ram_dat_i = 16'hBEEF;
    #1;
    total++; if (cpu_ack_o !== 1'b1 || cpu_dat_o !== 16'hBEEF || vid_ack_o !== 1'b0) begin bad++; $display("FAIL rd_ack cpu_ack=%b dat=%h vid_ack=%b exp 1/BEEF/0", cpu_ack_o, cpu_dat_o, vid_ack_o); end
    tick();
    ram_ack_i = 1'b0; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL rd_release got=%b exp=00", grant_o); end
  endtask

  task automatic test_cpu_write();
    int acks = 0;
    cpu_adr_i = 17'h1ABCD; cpu_dat_i = 16'h12AB; cpu_sel_i = 2'b10; cpu_we_i = 1'b1;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    tick();
    total++; if (ram_wen_o !== 1'b0 || ram_oen_o !== 1'b1) begin bad++; $display("FAIL wr_strobes wen=%b oen=%b exp 0/1", ram_wen_o, ram_oen_o); end
    total++; if (ram_sel_o !== 2'b10 || ram_dat_o !== 16'h12AB || ram_adr_o !== 17'h1ABCD) begin bad++; $display("FAIL wr_pins sel=%b dat=%h adr=%h exp 10/12AB/1ABCD", ram_sel_o, ram_dat_o, ram_adr_o); end
    for (int i = 0; i < 4; i++) begin
      ram_ack_i = (i == 1) || (i == 3);
      #1;
      if (cpu_ack_o) acks++;
      tick();
    end
    ram_ack_i = 1'b0;
    total++; if (acks != 2) begin bad++; $display("FAIL wr_ack_count got=%0d exp=2", acks); end
  endtask

  task automatic test_reset_mid_write();
    #2;
    total++; if (ram_wen_o !== 1'b0) begin bad++; $display("FAIL rst_pre_wen got=%b exp=0", ram_wen_o); end
    ram_ack_i = 1'b1;
    reset_i = 1'b1;
    #1;
    total++; if (ram_wen_o !== 1'b1 || grant_o !== 2'b00) begin bad++; $display("FAIL rst_async wen=%b grant=%b exp 1/00", ram_wen_o, grant_o); end
    total++; if (cpu_ack_o !== 1'b0) begin bad++; $display("FAIL rst_no_ack got=%b exp=0", cpu_ack_o); end
    idle_inputs();
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_spurious_ack();
    int seen = 0;
    ram_ack_i = 1'b1; ram_dat_i = 16'h5A5A;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (cpu_ack_o || vid_ack_o || grant_o != 2'b00) seen++;
      tick();
    end
    ram_ack_i = 1'b0;
    total++; if (seen != 0) begin bad++; $display("FAIL spurious_ack cycles_bad=%0d exp=0", seen); end
  endtask

  task automatic test_burst_limit();
    int vacks = 0;
    int cpu_leak = 0;
    int beats = 0;
    cpu_adr_i = 17'h00200; cpu_we_i = 1'b0; cpu_sel_i = 2'b11;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1;
    vid_adr_i = 17'h00100; vid_stb_i = 1'b1;
    tick();
    total++; if (grant_o !== 2'b10 || ram_adr_o !== 17'h00100 || ram_sel_o !== 2'b11 || ram_oen_o !== 1'b0) begin bad++; $display("FAIL sim_vid_first grant=%b adr=%h sel=%b oen=%b exp 10/00100/11/0", grant_o, ram_adr_o, ram_sel_o, ram_oen_o); end
    ram_ack_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (grant_o != 2'b10) break;
      if (vid_ack_o) vacks++;
      if (cpu_ack_o) cpu_leak++;
      tick();
    end
    total++; if (vacks != 8) begin bad++; $display("FAIL burst_vid_acks got=%0d exp=8", vacks); end
    total++; if (cpu_leak != 0) begin bad++; $display("FAIL burst_cpu_leak got=%0d exp=0", cpu_leak); end
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL burst_handover got=%b exp=01", grant_o); end
    for (int i = 0; i < 4; i++) begin
      #1;
      if (grant_o == 2'b01 && cpu_ack_o && !vid_ack_o && ram_adr_o == 17'h00200) beats++;
      tick();
    end
    total++; if (beats != 4) begin bad++; $display("FAIL cpu_atomic_beats got=%0d exp=4", beats); end
    ram_ack_i = 1'b0; cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    tick();
    total++; if (grant_o !== 2'b10) begin bad++; $display("FAIL back_to_vid got=%b exp=10", grant_o); end
    vid_stb_i = 1'b0;
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL vid_release got=%b exp=00", grant_o); end
  endtask

  task automatic test_vid_drop();
    int vacks = 0;
    cpu_cyc_i = 1'b1; cpu_stb_i = 1'b1; cpu_we_i = 1'b0;
    vid_stb_i = 1'b1; vid_adr_i = 17'h00300;
    tick();
    ram_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (vid_ack_o) vacks++;
      tick();
    end
    ram_ack_i = 1'b0; vid_stb_i = 1'b0;
    total++; if (vacks != 3) begin bad++; $display("FAIL drop_vid_acks got=%0d exp=3", vacks); end
    tick();
    total++; if (grant_o !== 2'b00) begin bad++; $display("FAIL drop_to_idle got=%b exp=00", grant_o); end
    tick();
    total++; if (grant_o !== 2'b01) begin bad++; $display("FAIL drop_cpu_grant got=%b exp=01", grant_o); end
    cpu_cyc_i = 1'b0; cpu_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_reset_mid_write();
    test_spurious_ack();
    test_burst_limit();
    test_vid_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
